// File: rtl/deferred_event_assign_pkg.sv
// Shared types for the deferred-assignment unit: channel state and timeout counter sizing.
// Timeout counter only exists when DEFERRED_EVENT_ASSIGN_TIMEOUT_EN is defined.
package deferred_event_assign_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Width of a counter that must hold values up to timeout inclusive.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/deferred_event_chan.sv
// One deferred-assignment channel: captures arm_data when armed, commits it on a strictly later event.
// Arm-to-value latency is 2 edges minimum; no backpressure. DEFERRED_EVENT_ASSIGN_TIMEOUT_EN adds discard-on-timeout.
module deferred_event_chan
  import deferred_event_assign_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm_valid,
  input  logic [WIDTH-1:0] arm_data,
  input  logic             event_in,
  output logic [WIDTH-1:0] value,
  output logic             written,
  output logic             armed,
  output logic             commit,
  output logic             timed_out
);

  state_t           state;
  logic [WIDTH-1:0] pending;

`ifdef DEFERRED_EVENT_ASSIGN_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT);
  logic [CW-1:0] cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      value     <= '0;
      written   <= 1'b0;
      armed     <= 1'b0;
      commit    <= 1'b0;
      timed_out <= 1'b0;
`ifdef DEFERRED_EVENT_ASSIGN_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      commit    <= 1'b0;
      timed_out <= 1'b0;
      if (state == IDLE) begin
        // An event in the arming cycle is ignored: commit must follow the arm strictly.
        if (arm_valid) begin
          state   <= ARMED;
          armed   <= 1'b1;
          pending <= arm_data;
`ifdef DEFERRED_EVENT_ASSIGN_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
      end else begin
        if (event_in) begin
          value   <= pending;
          written <= 1'b1;
          commit  <= 1'b1;
        end
        if (arm_valid) begin
          pending <= arm_data;
`ifdef DEFERRED_EVENT_ASSIGN_TIMEOUT_EN
          cnt     <= '0;
`endif
        end else if (event_in) begin
          state <= IDLE;
          armed <= 1'b0;
        end
`ifdef DEFERRED_EVENT_ASSIGN_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state     <= IDLE;
          armed     <= 1'b0;
          timed_out <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
`endif
      end
    end
  end

`ifndef DEFERRED_EVENT_ASSIGN_TIMEOUT_EN
  // Without the timeout feature TIMEOUT has no effect.
`endif

endmodule

// File: rtl/deferred_event_assign.sv
// Multi-channel deferred assignment (lhs <= @ev rhs); per-channel event ORed with a broadcast event.
// Arm-to-value latency 2 edges minimum; no backpressure. Optional timeout via DEFERRED_EVENT_ASSIGN_TIMEOUT_EN.
module deferred_event_assign #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       arm_valid,
  input  logic [CHANNELS*WIDTH-1:0] arm_data,
  input  logic [CHANNELS-1:0]       event_pulse,
  input  logic                      event_bcast,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       written,
  output logic [CHANNELS-1:0]       armed,
  output logic [CHANNELS-1:0]       commit,
  output logic [CHANNELS-1:0]       timed_out
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    deferred_event_chan #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .arm_valid (arm_valid[i]),
      .arm_data  (arm_data[i*WIDTH +: WIDTH]),
      .event_in  (event_pulse[i] | event_bcast),
      .value     (value[i*WIDTH +: WIDTH]),
      .written   (written[i]),
      .armed     (armed[i]),
      .commit    (commit[i]),
      .timed_out (timed_out[i])
    );
  end

endmodule

// File: tb/tb_deferred_event_assign.sv
// Directed plan plus random traffic checked each cycle against a behavioural channel model.
module tb_deferred_event_assign;
  localparam int CH = 4;
  localparam int W  = 4;
  localparam int TO = 3;
`ifdef DEFERRED_EVENT_ASSIGN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   arm_valid, event_pulse;
  logic            event_bcast;
  logic [CH*W-1:0] arm_data, value;
  logic [CH-1:0]   written, armed, commit, timed_out;

  always #5 clk = ~clk;

  deferred_event_assign #(.CHANNELS(CH), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .arm_valid   (arm_valid),
    .arm_data    (arm_data),
    .event_pulse (event_pulse),
    .event_bcast (event_bcast),
    .value       (value),
    .written     (written),
    .armed       (armed),
    .commit      (commit),
    .timed_out   (timed_out)
  );

  int errors = 0;
  int checks = 0;

  // Model: each channel either holds a pending value (with its age in edges) or not.
  logic [W-1:0] m_val [CH];
  logic [W-1:0] m_pend[CH];
  bit           m_has [CH];
  bit           m_wr  [CH];
  bit           m_cm  [CH];
  bit           m_to  [CH];
  int           m_age [CH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic [CH-1:0] av, input logic [CH*W-1:0] ad,
                            input logic [CH-1:0] ep, input logic eb, input logic rst);
    for (int i = 0; i < CH; i++) begin
      bit ev;
      ev = ep[i] | eb;
      m_cm[i] = 0;
      m_to[i] = 0;
      if (rst) begin
        m_val[i] = '0; m_pend[i] = '0; m_has[i] = 0; m_wr[i] = 0; m_age[i] = 0;
      end else if (!m_has[i]) begin
        if (av[i]) begin
          m_has[i] = 1; m_pend[i] = ad[i*W +: W]; m_age[i] = 0;
        end
      end else begin
        logic [W-1:0] old;
        old = m_pend[i];
        if (ev) begin
          m_val[i] = old; m_wr[i] = 1; m_cm[i] = 1;
        end
        if (av[i]) begin
          m_pend[i] = ad[i*W +: W]; m_age[i] = 0;
        end else if (ev) begin
          m_has[i] = 0;
        end else begin
          m_age[i] = m_age[i] + 1;
          if (TO_EN && m_age[i] >= TO) begin
            m_has[i] = 0; m_to[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [CH*W-1:0] ev_val;
    logic [CH-1:0]   ev_wr, ev_arm, ev_cm, ev_to;
    for (int i = 0; i < CH; i++) begin
      ev_val[i*W +: W] = m_val[i];
      ev_wr[i] = m_wr[i]; ev_arm[i] = m_has[i]; ev_cm[i] = m_cm[i]; ev_to[i] = m_to[i];
    end
    chk("value", value, ev_val);
    chk("written", written, ev_wr);
    chk("armed", armed, ev_arm);
    chk("commit", commit, ev_cm);
    chk("timed_out", timed_out, ev_to);
  endtask

  task automatic tick(input logic [CH-1:0] av, input logic [CH*W-1:0] ad,
                      input logic [CH-1:0] ep, input logic eb, input logic rst);
    arm_valid = av; arm_data = ad; event_pulse = ep; event_bcast = eb; reset = rst;
    @(posedge clk);
    model_edge(av, ad, ep, eb, rst);
    #1;
    compare_all();
  endtask

  task automatic idle();
    tick('0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    arm_valid = '0; arm_data = '0; event_pulse = '0; event_bcast = 1'b0; reset = 1'b1;
    for (int i = 0; i < CH; i++) begin
      m_val[i] = '0; m_pend[i] = '0; m_has[i] = 0; m_wr[i] = 0; m_cm[i] = 0; m_to[i] = 0; m_age[i] = 0;
    end

    tick('0, '0, '0, 1'b0, 1'b1);
    tick('0, '0, '0, 1'b0, 1'b1);
    chk("rst_value", value, 16'h0000);
    chk("rst_armed", {written, armed, commit, timed_out}, 16'h0000);

    // Arm ch0 with A, event three cycles later.
    tick(4'b0001, 16'h000A, '0, 1'b0, 1'b0);
    chk("t1_armed", armed, 4'b0001);
    idle(); idle();
    tick('0, '0, 4'b0001, 1'b0, 1'b0);
    chk("t1_value", value, 16'h000A);
    chk("t1_commit", commit, 4'b0001);
    chk("t1_written", written, 4'b0001);
    idle();
    chk("t1_commit_drop", commit, 4'b0000);

    // Arm and event together on ch1: no commit until a later event.
    tick(4'b0010, 16'h0030, 4'b0010, 1'b0, 1'b0);
    chk("t2_no_commit", commit, 4'b0000);
    idle();
    tick('0, '0, 4'b0010, 1'b0, 1'b0);
    chk("t2_value", value[7:4], 4'h3);
    chk("t2_commit", commit, 4'b0010);

    // Re-arm: latest wins on ch2; arm+event on ch3 commits old, holds new.
    tick(4'b0100, 16'h0500, '0, 1'b0, 1'b0);
    tick(4'b0100, 16'h0900, '0, 1'b0, 1'b0);
    tick('0, '0, 4'b0100, 1'b0, 1'b0);
    chk("t3_ch2", value[11:8], 4'h9);
    tick(4'b1000, 16'h1000, '0, 1'b0, 1'b0);
    tick(4'b1000, 16'h2000, 4'b1000, 1'b0, 1'b0);
    chk("t3_ch3_old", value[15:12], 4'h1);
    chk("t3_ch3_armed", armed[3], 1'b1);
    tick('0, '0, 4'b1000, 1'b0, 1'b0);
    chk("t3_ch3_new", value[15:12], 4'h2);

    // Broadcast commits all channels on one edge.
    tick(4'b1111, 16'h4321, '0, 1'b0, 1'b0);
    tick('0, '0, '0, 1'b1, 1'b0);
    chk("t4_value", value, 16'h4321);
    chk("t4_commit", commit, 4'b1111);
    chk("t4_armed", armed, 4'b0000);
    tick('0, '0, '0, 1'b1, 1'b0);
    chk("t4_back2back", commit, 4'b0000);

`ifdef DEFERRED_EVENT_ASSIGN_TIMEOUT_EN
    tick('0, '0, '0, 1'b0, 1'b1);
    tick(4'b0001, 16'h000F, '0, 1'b0, 1'b0);
    idle(); idle();
    chk("to_not_yet", timed_out, 4'b0000);
    idle();
    chk("to_pulse", timed_out, 4'b0001);
    chk("to_value", value, 16'h0000);
    chk("to_written", written, 4'b0000);
    tick(4'b0001, 16'h000F, '0, 1'b0, 1'b0);
    idle(); idle();
    tick('0, '0, 4'b0001, 1'b0, 1'b0);
    chk("to_ev_commit", commit, 4'b0001);
    chk("to_ev_no_to", timed_out, 4'b0000);
    chk("to_ev_value", value[3:0], 4'hF);
`endif

    // Reset discards a pending value.
    tick(4'b0001, 16'h0007, '0, 1'b0, 1'b0);
    tick('0, '0, '0, 1'b0, 1'b1);
    tick('0, '0, 4'b0001, 1'b0, 1'b0);
    chk("rst_no_commit", commit, 4'b0000);
    chk("rst_value0", value, 16'h0000);
    chk("rst_clear", {armed, written}, 8'h00);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      logic [CH-1:0]   av, ep;
      logic [CH*W-1:0] ad;
      logic            eb, rs;
      for (int i = 0; i < CH; i++) begin
        av[i] = ($urandom_range(0, 3) == 0);
        ep[i] = ($urandom_range(0, 3) == 0);
      end
      ad = 16'($urandom);
      eb = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 63) == 0);
      tick(av, ad, ep, eb, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/deferred_event_assign.md
# deferred_event_assign

Multi-channel deferred-assignment unit implementing intra-assignment event control in hardware. Each channel captures a right-hand-side value when armed and commits it to its output only when a later event arrives, generalising the single-register `lhs <= @ev rhs` pattern. The unit is parametrised in channel count and data width, and adds a broadcast event, re-arm semantics and an optional timeout. It sits between producers that compute values early and consumers that must observe them only at event boundaries.

## Interface
- CHANNELS, 4, number of independent deferred-assignment channels (≥1)
- WIDTH, 4, data width per channel (≥1)
- TIMEOUT, 15, cycles an armed channel waits for an event before discarding; used only with the timeout feature (≥1)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- arm_valid  in  CHANNELS  per-channel arm request; samples arm_data
- arm_data  in  CHANNELS*WIDTH  per-channel RHS value; channel i uses bits [i*WIDTH +: WIDTH]
- event_pulse  in  CHANNELS  per-channel event
- event_bcast  in  1  event delivered to every channel
- value  out  CHANNELS*WIDTH  committed LHS value per channel
- written  out  CHANNELS  channel has committed at least once since reset
- armed  out  CHANNELS  channel holds a pending value
- commit  out  CHANNELS  one-cycle pulse, high in the cycle after a commit edge
- timed_out  out  CHANNELS  one-cycle pulse on timeout discard; constant 0 without the timeout feature

## Operation
- Per-channel FSM with two states: IDLE and ARMED. The effective event for channel i is `event_pulse[i] | event_bcast`.
- IDLE, arm_valid: go to ARMED, pending ← arm_data, wait counter ← 0.
- IDLE, event without arm: ignored. No commit and no pulse.
- IDLE, arm and event in the same cycle: the event does not commit the newly sampled data. The event must arrive strictly after the arm. The channel goes to ARMED.
- ARMED, event without arm: value ← pending, written ← 1, commit pulse, go to IDLE.
- ARMED, arm without event: re-arm. pending ← arm_data (latest wins), counter ← 0, stay ARMED. No commit.
- ARMED, event and arm in the same cycle: commit the old pending value, capture the new arm_data as pending, counter ← 0, stay ARMED.
- Channels are fully independent. A broadcast commits every ARMED channel on the same edge.
- Values are opaque bits. No arithmetic is performed; X/Z on arm_data propagates unchanged.

## Timing
- All outputs are registered.
- Reset values: value = 0, written = 0, armed = 0, commit = 0, timed_out = 0, state = IDLE, counter = 0.
- Arm sampled at edge t: armed = 1 after t.
- Earliest commit happens at edge t+1. At that edge value updates and commit rises for one cycle.
- Arm-to-output latency is therefore 2 edges minimum, with no upper bound unless the timeout feature is enabled.
- Reset asserted in any state wins over every other input. Pending data is discarded, no commit or timeout pulse is produced, and all outputs return to their reset values on that edge.
- Back-to-back events with no intervening arm: only the first commits.

## Configuration
- DEFERRED_EVENT_ASSIGN_TIMEOUT_EN defined:
  - Each channel has a counter $clog2(TIMEOUT+1) bits wide, incremented every cycle while ARMED.
  - When the counter equals TIMEOUT-1 with no event and no arm, the channel goes to IDLE, value is unchanged and timed_out pulses for one cycle.
  - An event in the expiry cycle wins: the channel commits with no timeout.
  - An arm in the expiry cycle re-arms with no timeout.
- Macro undefined: no counter is built. ARMED persists until an event, and timed_out is tied to 0.

## Structure
- Package deferred_event_assign_pkg:
  - state typedef with two states, IDLE and ARMED.
  - Localparam helper for the counter width.
- Sub-module deferred_event_chan: one channel's FSM, pending register, value register and counter. The top instantiates CHANNELS copies in a generate loop and performs the event OR and bus slicing only.

## Test plan
- Reset, then arm channel 0 with 4'hA at cycle 2 and pulse event_pulse[0] at cycle 5 → value[3:0] = 4'hA from cycle 6, commit[0] high exactly at cycle 6, written[0] = 1, other channels still 0.
- Arm channel 1 with 4'h3 and event_pulse[1] in the same cycle, then an event two cycles later → no commit on the first event. value[7:4] = 4'h3 only after the second event.
- Channel 2: arm 4'h5, then arm 4'h9, then event → value = 4'h9. Channel 3: arm 4'h1, then arm 4'h2 together with an event → commits 4'h1, stays armed holding 4'h2.
- Arm all four channels with 4'h1, 4'h2, 4'h3, 4'h4, then event_bcast → all commit on the same edge with the matching values, and all armed bits clear.
- With DEFERRED_EVENT_ASSIGN_TIMEOUT_EN and TIMEOUT=3, arm channel 0 with 4'hF and send no event → timed_out[0] pulses at the expected edge, value stays 0 and written stays 0. Repeat with the event placed in the expiry cycle → commit and no timeout.
- Arm channel 0, assert reset for one cycle, then send an event → no commit, and value, armed and written are all 0.
